branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 138 +++++++++++++
 tb/tb_branch_resolve.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: stalls on pending operands, redirects PC one cycle after a taken branch.
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_resolve #(
    parameter int SIZE      = 31,
    parameter int STALL_MAX = 3,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_eq,
    input  logic            branch_ne,
    input  logic            equal_inputs,
    input  logic            operand_pending,
    input  logic [SIZE:0]   pc_plus4,
    input  logic [SIZE:0]   imm_sext,
    output logic            stall_id,
    output logic            pc_src,
    output logic [SIZE:0]   branch_target,
    output logic            flush_ifid,
    output logic            stall_error,
    output logic [1:0]      state_dbg
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] not_taken_count
`endif
);

    localparam int SC_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            pc_src_q, pc_src_d;
    logic            flush_q, flush_d;
    logic [SIZE:0]   target_q, target_d;
    logic            error_q, error_d;

    logic valid_br;
    logic taken;
    logic evaluating;

    always_comb begin
        valid_br   = branch_eq ^ branch_ne;
        taken      = valid_br & ((branch_eq & equal_inputs) | (branch_ne & ~equal_inputs));
        // REDIRECT ignores ID inputs, so evaluation only happens from IDLE or WAIT.
        evaluating = (state_q != S_REDIRECT) && valid_br && !operand_pending;

        state_d     = state_q;
        stall_cnt_d = '0;
        error_d     = error_q;
        target_d    = evaluating ? (pc_plus4 + {imm_sext[SIZE-2:0], 2'b00}) : target_q;

        case (state_q)
            S_IDLE: begin
                if (valid_br && operand_pending)
                    state_d = S_WAIT;
                else if (evaluating && taken)
                    state_d = S_REDIRECT;
            end
            S_WAIT: begin
                if (operand_pending) begin
                    stall_cnt_d = (int'(stall_cnt_q) < STALL_MAX) ? stall_cnt_q + SC_W'(1) : stall_cnt_q;
                    if (int'(stall_cnt_q) + 1 >= STALL_MAX)
                        error_d = 1'b1;
                end else begin
                    state_d = taken ? S_REDIRECT : S_IDLE;
                end
            end
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        pc_src_d = (state_d == S_REDIRECT);
        flush_d  = (state_d == S_REDIRECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= '0;
            pc_src_q    <= 1'b0;
            flush_q     <= 1'b0;
            target_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            pc_src_q    <= pc_src_d;
            flush_q     <= flush_d;
            target_q    <= target_d;
            error_q     <= error_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] nt_cnt_q, nt_cnt_d;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        nt_cnt_d    = nt_cnt_q;
        if (evaluating) begin
            if (taken && !(&taken_cnt_q))
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            if (!taken && !(&nt_cnt_q))
                nt_cnt_d = nt_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
            nt_cnt_q    <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            nt_cnt_q    <= nt_cnt_d;
        end
    end

    assign taken_count     = taken_cnt_q;
    assign not_taken_count = nt_cnt_q;
`endif

    // Gated with rst_n so every output reads 0 while reset is held.
    assign stall_id      = rst_n && (state_q != S_REDIRECT) && valid_br && operand_pending;
    assign pc_src        = pc_src_q;
    assign flush_ifid    = flush_q;
    assign branch_target = target_q;
    assign stall_error   = error_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: redirect timing, stalls, stall error, wrap, reset abort.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        branch_eq;
    logic        branch_ne;
    logic        equal_inputs;
    logic        operand_pending;
    logic [31:0] pc_plus4;
    logic [31:0] imm_sext;
    logic        stall_id;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        flush_ifid;
    logic        stall_error;
    logic [1:0]  state_dbg;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_count;
    logic [15:0] not_taken_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolve dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .branch_eq       (branch_eq),
        .branch_ne       (branch_ne),
        .equal_inputs    (equal_inputs),
        .operand_pending (operand_pending),
        .pc_plus4        (pc_plus4),
        .imm_sext        (imm_sext),
        .stall_id        (stall_id),
        .pc_src          (pc_src),
        .branch_target   (branch_target),
        .flush_ifid      (flush_ifid),
        .stall_error     (stall_error),
        .state_dbg       (state_dbg)
`ifdef BRANCH_STATS_EN
        ,
        .taken_count     (taken_count),
        .not_taken_count (not_taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic beq, input logic bne, input logic eq, input logic pend,
                          input logic [31:0] pc, input logic [31:0] imm);
        branch_eq       = beq;
        branch_ne       = bne;
        equal_inputs    = eq;
        operand_pending = pend;
        pc_plus4        = pc;
        imm_sext        = imm;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("rst_stall_id", stall_id, 0);
        chk("rst_pc_src", pc_src, 0);
        chk("rst_flush", flush_ifid, 0);
        chk("rst_target", branch_target, 0);
        chk("rst_error", stall_error, 0);
        chk("rst_state", state_dbg, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // BEQ taken, no pending operand
        set_in(1, 0, 1, 0, 32'h100, 32'h4);
        #1;
        chk("beq_stall", stall_id, 0);
        tick();
        chk("beq_pc_src", pc_src, 1);
        chk("beq_flush", flush_ifid, 1);
        chk("beq_target", branch_target, 32'h110);
        // inputs during REDIRECT must be ignored
        set_in(1, 0, 1, 1, 32'h200, 32'h1);
        #1;
        chk("redir_stall", stall_id, 0);
        tick();
        chk("redir_pc_src_off", pc_src, 0);
        chk("redir_flush_off", flush_ifid, 0);
        chk("redir_target_hold", branch_target, 32'h110);
        chk("redir_state_idle", state_dbg, 0);
        set_in(0, 0, 0, 0, 32'h0, 32'h0);

        // BNE with equal operands: not taken
        set_in(0, 1, 1, 0, 32'h300, 32'h8);
        #1;
        chk("bne_nt_stall", stall_id, 0);
        tick();
        chk("bne_nt_pc_src", pc_src, 0);
        chk("bne_nt_flush", flush_ifid, 0);
`ifdef BRANCH_STATS_EN
        chk("stats_nt_1", not_taken_count, 1);
        chk("stats_t_1", taken_count, 1);
`endif

        // BNE taken with negative offset
        set_in(0, 1, 0, 0, 32'h40, 32'hFFFF_FFFF);
        tick();
        chk("bne_t_pc_src", pc_src, 1);
        chk("bne_t_target", branch_target, 32'h3C);
        set_in(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("bne_t_pc_src_off", pc_src, 0);

        // BEQ pending two cycles, then taken
        set_in(1, 0, 1, 1, 32'h1000, 32'h10);
        #1;
        chk("pend2_stall_idle", stall_id, 1);
        tick();
        chk("pend2_stall_wait", stall_id, 1);
        chk("pend2_state_wait", state_dbg, 1);
        chk("pend2_no_redirect", pc_src, 0);
        tick();
        chk("pend2_err_mid", stall_error, 0);
        operand_pending = 1'b0;
        #1;
        chk("pend2_stall_off", stall_id, 0);
        tick();
        chk("pend2_pc_src", pc_src, 1);
        chk("pend2_target", branch_target, 32'h1040);
        chk("pend2_err", stall_error, 0);
        set_in(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("pend2_pc_src_off", pc_src, 0);

        // pending three cycles: just below the error threshold, not taken
        set_in(1, 0, 0, 1, 32'h1000, 32'h10);
        repeat (3) tick();
        chk("pend3_stall", stall_id, 1);
        chk("pend3_err", stall_error, 0);
        operand_pending = 1'b0;
        tick();
        chk("pend3_pc_src", pc_src, 0);
        chk("pend3_state", state_dbg, 0);
        chk("pend3_err_after", stall_error, 0);
        set_in(0, 0, 0, 0, 32'h0, 32'h0);

        // target wraps modulo 2^32
        set_in(1, 0, 1, 0, 32'hFFFF_FFFC, 32'h1);
        tick();
        chk("wrap_pc_src", pc_src, 1);
        chk("wrap_target", branch_target, 32'h0);
        set_in(0, 0, 0, 0, 32'h0, 32'h0);
        tick();

        // both branch flags high: no branch
        set_in(1, 1, 1, 1, 32'h500, 32'h4);
        #1;
        chk("both_stall", stall_id, 0);
        tick();
        chk("both_pc_src", pc_src, 0);
        chk("both_state", state_dbg, 0);
        operand_pending = 1'b0;
        tick();
        chk("both_pc_src_np", pc_src, 0);
        chk("both_target_hold", branch_target, 32'h0);
        set_in(0, 0, 0, 0, 32'h0, 32'h0);

        // pending four cycles: sticky stall error
        set_in(1, 0, 1, 1, 32'h2000, 32'h1);
        repeat (3) tick();
        chk("pend4_err_before", stall_error, 0);
        tick();
        chk("pend4_err", stall_error, 1);
        chk("pend4_stall", stall_id, 1);
        chk("pend4_state", state_dbg, 1);
        operand_pending = 1'b0;
        tick();
        chk("pend4_pc_src", pc_src, 1);
        chk("pend4_target", branch_target, 32'h2004);
        chk("pend4_err_sticky", stall_error, 1);
        set_in(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("pend4_pc_src_off", pc_src, 0);
        chk("pend4_err_sticky2", stall_error, 1);
`ifdef BRANCH_STATS_EN
        chk("stats_t_5", taken_count, 5);
        chk("stats_nt_2", not_taken_count, 2);
`endif

        // asynchronous reset in the middle of WAIT
        set_in(0, 1, 0, 1, 32'h3000, 32'h4);
        tick();
        chk("abort_state_wait", state_dbg, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_stall", stall_id, 0);
        chk("abort_pc_src", pc_src, 0);
        chk("abort_flush", flush_ifid, 0);
        chk("abort_target", branch_target, 0);
        chk("abort_err", stall_error, 0);
        chk("abort_state", state_dbg, 0);
`ifdef BRANCH_STATS_EN
        chk("abort_stats_t", taken_count, 0);
        chk("abort_stats_nt", not_taken_count, 0);
`endif
        set_in(0, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("abort_no_redirect", pc_src, 0);
        chk("abort_idle", state_dbg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
